// File: rtl/neuron_mac_par.sv
// Parallel-lane ELM hidden neuron: weight memory, LANES-wide MAC pipeline, bias, saturation and activation.
// Optional build macro NEURON_MAC_ROUND_EN selects round-half-up instead of truncation in the final shift.
module neuron_mac_par #(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int NUM_WEIGHT = 128,
  parameter int LANES      = 4,
  parameter int CFG_W      = 8,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_W-1:0]          cfg_layer,
  input  logic [CFG_W-1:0]          cfg_neuron,
  input  logic                      weight_valid,
  input  logic [DATA_W-1:0]         weight_value,
  input  logic                      bias_valid,
  input  logic [DATA_W-1:0]         bias_value,
  input  logic [1:0]                act_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  localparam int ROWS   = NUM_WEIGHT / LANES;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(NUM_WEIGHT);
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PTR_W  = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ROWS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_WEIGHT - 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (DATA_W - 1)));

  localparam logic signed [DATA_W:0] HS_HALF = (DATA_W + 1)'(2 ** (FRAC_W - 1));
  localparam logic signed [DATA_W:0] HS_ONE  = (DATA_W + 1)'(2 ** FRAC_W);
  localparam logic signed [DATA_W:0] HS_ZERO = (DATA_W + 1)'(0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_ACT   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   bias_q, bias_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      busy_q, busy_d;
  logic [DATA_W-1:0]         sat_q, sat_d;

  logic                      s1_valid_q, s1_valid_d;
  logic [LANES*DATA_W-1:0]   w_row_q, w_row_d;
  logic [LANES*DATA_W-1:0]   x_row_q, x_row_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [LANES*PROD_W-1:0]   prod_q, prod_d;

  logic [DATA_W-1:0]         mem_q [NUM_WEIGHT];

  logic                      match_s;
  logic                      accept_s;
  logic                      consume_s;
  logic                      wr_en_s;
  logic signed [ACC_W-1:0]   bias_ext_s;
  logic signed [ACC_W-1:0]   lane_sum_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic signed [SUM_W-1:0]   rnd_s;
  logic signed [SUM_W-1:0]   shifted_s;
  logic [DATA_W-1:0]         sat_s;
  logic signed [DATA_W:0]    xe_s;
  logic signed [DATA_W:0]    hs_s;
  logic [DATA_W-1:0]         hs_clamp_s;
  logic [DATA_W-1:0]         act_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Handshake qualifiers and config-bus decode
  always_comb begin
    match_s   = (cfg_layer == CFG_W'(LAYER_NO)) && (cfg_neuron == CFG_W'(NEURON_NO));
    accept_s  = in_valid && in_ready_q && ((state_q == S_IDLE) || (state_q == S_ACCUM));
    consume_s = out_valid_q && out_ready && (state_q == S_HOLD);
    wr_en_s   = weight_valid && match_s && (state_q == S_IDLE) && (beat_cnt_q == '0);
  end

  // Weight pointer and bias register updates
  always_comb begin
    ptr_d      = ptr_q;
    bias_d     = bias_q;
    bias_ext_s = ACC_W'($signed(bias_value));
    if (wr_en_s) begin
      if (ptr_q == LAST_PTR) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    if (bias_valid && match_s && !busy_q) begin
      bias_d = bias_ext_s <<< FRAC_W;
    end else begin
      bias_d = bias_q;
    end
  end

  // MAC pipeline: row fetch, lane products, accumulate
  always_comb begin
    s1_valid_d = accept_s;
    w_row_d    = w_row_q;
    x_row_d    = x_row_q;
    if (accept_s) begin
      for (int l = 0; l < LANES; l++) begin
        w_row_d[l*DATA_W +: DATA_W] = mem_q[PTR_W'(int'(beat_cnt_q) * LANES + l)];
      end
      x_row_d = in_data;
    end else begin
      w_row_d = w_row_q;
      x_row_d = x_row_q;
    end

    s2_valid_d = s1_valid_q;
    prod_d     = prod_q;
    if (s1_valid_q) begin
      for (int l = 0; l < LANES; l++) begin
        prod_d[l*PROD_W +: PROD_W] = PROD_W'($signed(x_row_q[l*DATA_W +: DATA_W]))
                                   * PROD_W'($signed(w_row_q[l*DATA_W +: DATA_W]));
      end
    end else begin
      prod_d = prod_q;
    end

    lane_sum_s = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_s = lane_sum_s + ACC_W'($signed(prod_q[l*PROD_W +: PROD_W]));
    end

    if (consume_s) begin
      acc_d = '0;
    end else if (s2_valid_q) begin
      acc_d = acc_q + lane_sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Bias add, Q-format rescale and saturation to the output range
  always_comb begin
    sum_s = SUM_W'(acc_q) + SUM_W'(bias_q);
`ifdef NEURON_MAC_ROUND_EN
    rnd_s = sum_s + (SUM_W'(1) << (FRAC_W - 1));
`else
    rnd_s = sum_s;
`endif
    shifted_s = rnd_s >>> FRAC_W;
    if (shifted_s > SAT_MAX) begin
      sat_s = {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (shifted_s < SAT_MIN) begin
      sat_s = {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      sat_s = shifted_s[DATA_W-1:0];
    end
  end

  // Activation on the saturated value
  always_comb begin
    xe_s = {sat_q[DATA_W-1], sat_q};
    hs_s = (xe_s >>> 2) + HS_HALF;
    if (hs_s < HS_ZERO) begin
      hs_clamp_s = '0;
    end else if (hs_s > HS_ONE) begin
      hs_clamp_s = HS_ONE[DATA_W-1:0];
    end else begin
      hs_clamp_s = hs_s[DATA_W-1:0];
    end
    case (act_mode)
      2'd1:    act_s = sat_q[DATA_W-1] ? '0 : sat_q;
      2'd2:    act_s = hs_clamp_s;
      default: act_s = sat_q;
    endcase
  end

  // Frame sequencing: beat counting, drain, finalise, activate, hold
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    sat_d       = sat_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept_s) begin
          busy_d = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
          end else begin
            state_d    = S_ACCUM;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DRAIN: begin
        // The last product reaches the accumulator on the edge leaving this state.
        if (!s1_valid_q) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINAL: begin
        sat_d   = sat_s;
        state_d = S_ACT;
      end
      S_ACT: begin
        out_data_d  = act_s;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          beat_cnt_d  = '0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_IDLE;
        beat_cnt_d  = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Control and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      sat_q       <= '0;
      s1_valid_q  <= 1'b0;
      w_row_q     <= '0;
      x_row_q     <= '0;
      s2_valid_q  <= 1'b0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      sat_q       <= sat_d;
      s1_valid_q  <= s1_valid_d;
      w_row_q     <= w_row_d;
      x_row_q     <= x_row_d;
      s2_valid_q  <= s2_valid_d;
      prod_q      <= prod_d;
    end
  end

  // Weight memory keeps its contents through reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[ptr_q] <= weight_value;
    end
  end

endmodule

// File: doc/neuron_mac_par.md
Name: neuron_mac_par

Overview:
- Parametrised successor of the single-lane ELM hidden neuron.
- Holds NUM_WEIGHT weights in an internal memory and consumes LANES inputs per beat. Accumulates lane products, adds a Q(FRAC_W) bias, then applies a runtime-selected activation: identity, ReLU or hard-sigmoid.
- Result is presented on a valid/ready output with backpressure.
- Sits in a layer array, one instance per neuron. Weights and bias load over the shared config bus.

Parameters:
- DATA_W, 16, signed data/weight/bias/output width
- FRAC_W, 8, fractional bits of data, weight, bias and output (Q format)
- NUM_WEIGHT, 128, weights per neuron; must be a multiple of LANES
- LANES, 4, inputs consumed per accepted beat
- CFG_W, 8, width of layer/neuron select fields
- LAYER_NO, 1, layer id matched on the config bus
- NEURON_NO, 0, neuron id matched on the config bus

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- cfg_layer  in  CFG_W  config bus layer select
- cfg_neuron  in  CFG_W  config bus neuron select
- weight_valid  in  1  weight_value write strobe
- weight_value  in  DATA_W  weight, Q(FRAC_W)
- bias_valid  in  1  bias_value write strobe
- bias_value  in  DATA_W  bias, Q(FRAC_W)
- act_mode  in  2  activation select: 0 identity, 1 ReLU, 2 hard-sigmoid, 3 identity
- in_valid  in  1  input beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  LANES*DATA_W  packed inputs; lane i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  DATA_W  activated result, Q(FRAC_W)
- busy  out  1  high from first accepted beat until result consumed

Behaviour:
- Reset (rst=0 at a clock edge) sets:
  - state IDLE, beat count 0, write pointer 0, accumulator 0, bias 0
  - out_valid 0, out_data 0, busy 0, in_ready 1
  - Weight memory contents are retained.
  - Reset mid-frame aborts the frame; no output is produced.
- Config match: cfg_layer==LAYER_NO and cfg_neuron==NEURON_NO.
- Weight load: weight_valid & match & state==IDLE & beat count==0.
  - Writes weight_value at the write pointer. Weight j is stored in row j/LANES, lane j%LANES.
  - Pointer wraps NUM_WEIGHT-1 -> 0.
  - Writes while busy are dropped.
- Bias load: bias_valid & match & !busy latches bias_value. Stored sign-extended to accumulator width and shifted left by FRAC_W.
- Accumulator width: ACC_W = 2*DATA_W + clog2(NUM_WEIGHT). Arithmetic is signed two's complement with no intermediate overflow.
- FSM states and transitions:
  - IDLE/ACCUM: in_ready=1. Each accepted beat reads memory row = beat count, then increments the count. The beat with count==NUM_WEIGHT/LANES-1 moves to DRAIN and in_ready drops the next cycle.
  - DRAIN: waits for the pipeline to empty.
  - FINAL: add bias, shift right arithmetic by FRAC_W, saturate to DATA_W [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ACT: apply activation, register out_data, set out_valid.
  - HOLD: out_valid=1, out_data stable until out_ready; then return to IDLE with beat count and accumulator cleared.
- Pipeline, for a beat accepted at cycle t:
  - t+1: weight row and inputs registered.
  - t+2: LANES products (2*DATA_W each) registered.
  - t+3: lane sum added to the accumulator.
- Latency: out_valid asserts exactly 5 cycles after the last beat is accepted.
- Gaps in in_valid are allowed; the accumulator only updates for accepted beats.
- Activation, on saturated value x:
  - identity: x
  - ReLU: max(x, 0)
  - hard-sigmoid: clamp((x>>>2) + 2^(FRAC_W-1), 0, 2^FRAC_W)
- act_mode is sampled in the ACT state.
- No new beat is accepted in DRAIN, FINAL, ACT or HOLD.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN.
- Defined: the FINAL shift rounds half-up by adding 2^(FRAC_W-1) before the arithmetic shift right, then saturates.
- Undefined: plain truncating arithmetic shift.

Test Plan (DATA_W=16, FRAC_W=8, LANES=4, NUM_WEIGHT=8):
- Weights all 256, bias 0, two beats of all-128 inputs -> out_data after 5 cycles:
  - act_mode 0: 1024
  - act_mode 1: 1024
  - act_mode 2: 256
- Same weights, inputs all -128, bias 256 -> acc -3.0:
  - act_mode 0: -768
  - act_mode 1: 0
  - act_mode 2: 0 (clamp)
- Weights 32767, inputs 32767 -> out_data 32767. Inputs -32768 -> out_data -32768.
- Single weight0=128, input lane0=1, rest 0:
  - macro off: out_data 0
  - NEURON_MAC_ROUND_EN on: out_data 1
- out_ready low 3 cycles after out_valid -> out_data stable, in_ready 0, busy 1. weight_valid in that window is dropped, verified by next frame result.
- rst low after first beat -> out_valid stays 0. Next full frame gives the correct result with weights unchanged.
